mmio_periph_ctrl: RTL and testbench
===================================

MMIO_PERIPH_CTRL -- requirements
Module: mmio_periph_ctrl

Interface
REQ-001 SHALL have parameter WL, default 32: data bus width in bits.
REQ-002 SHALL have parameter ADDR_WL, default 4: register word-index width (16 registers).
REQ-003 SHALL have parameter N_GPI, default 8: number of general-purpose inputs (1..16).
REQ-004 SHALL have parameter N_GPO, default 8: number of general-purpose outputs (1..WL).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: depth of the UART TX FIFO and of the RX FIFO; power of 2, at least 2.
REQ-006 SHALL have parameter ID_VALUE, default 32'hA7C0_0001: constant returned by the ID register.
REQ-007 Ports SHALL be as follows; one clock; reset is synchronous and active-high.
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  cmd_valid  in  1  bus command strobe (one-cycle, always accepted)
  cmd_wr  in  1  1=write, 0=read
  cmd_addr  in  ADDR_WL+2  byte address; bits [1:0] ignored
  cmd_wdata  in  WL  write data
  rsp_valid  out  1  read response strobe
  rsp_data  out  WL  read data
  rsp_error  out  1  unmapped address on the read
  gpi  in  N_GPI  asynchronous inputs
  gpo  out  N_GPO  registered outputs
  uart_tx_rdy  in  1  transmitter idle
  uart_tx_vld  out  1  one-cycle byte-send pulse
  uart_tx_data  out  8  byte to send
  uart_rx_valid  in  1  received-byte pulse
  uart_rx_data  in  8  received byte
  irq  out  1  registered level interrupt

Function
REQ-008 Register map (word index): 0 ID RO; 1 GPO RW; 2 GPI RO; 3 GPI_EDGE W1C; 4 IRQ_EN RW [3:0]; 5 UART_TX WO; 6 UART_RX RO-pop; 7 STATUS RO; 8..15 unmapped.
REQ-009 Read: rsp_valid SHALL pulse exactly 1 cycle after a cmd_valid read; writes SHALL produce no response.
REQ-010 Read of an unmapped or WO address SHALL return rsp_data=0 and rsp_error=1; write to an unmapped or RO address SHALL be ignored.
REQ-011 GPI SHALL pass through a 2-flop synchroniser; GPI read returns the synchronised value, zero-extended.
REQ-012 GPI_EDGE bit i SHALL set on a synchronised rising edge; writing 1 clears it; set wins over clear in the same cycle.
REQ-013 Write to UART_TX SHALL push cmd_wdata[7:0] when the TX FIFO is not full; when full the byte is dropped and tx_ovf sets (sticky).
REQ-014 TX drain: when the TX FIFO is not empty, uart_tx_rdy=1 and uart_tx_vld=0, the block SHALL pop the head and pulse uart_tx_vld for 1 cycle with uart_tx_data=head; there SHALL be no back-to-back pulses.
REQ-015 uart_rx_valid SHALL push uart_rx_data when the RX FIFO is not full; when full the byte is dropped and rx_ovf sets (sticky).
REQ-016 Read of UART_RX when not empty SHALL return {1'b1, zeros, byte} and pop; when empty it SHALL return 0 with no pop.
REQ-017 Simultaneous push and pop on a FIFO SHALL both occur with the count unchanged; a push on a full FIFO is rejected even with a simultaneous pop.
REQ-018 STATUS fields: [7:0]=tx_count, [15:8]=rx_count, [16]=tx_full, [17]=rx_empty, [18]=tx_ovf, [19]=rx_ovf. Reading STATUS SHALL clear both ovf bits; a new overflow in the same cycle wins.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; counts SHALL range 0..FIFO_DEPTH.
REQ-020 irq (registered, 1-cycle latency) SHALL equal |(IRQ_EN & {tx_ovf|rx_ovf, |GPI_EDGE, tx_empty, !rx_empty}), with bit order [3:0].

Reset
REQ-021 On reset: gpo=0, IRQ_EN=0, GPI_EDGE=0, both FIFOs empty, ovf bits=0, rsp_valid=0, rsp_error=0, uart_tx_vld=0, irq=0, synchroniser flops=0.
REQ-022 Reset asserted mid-operation SHALL abort any pending response and TX pulse in the same edge; FIFO contents are discarded.

Verification
REQ-023 Write 0xA5 to GPO, then read GPO -> gpo=0xA5 after the write edge; rsp_valid 1 cycle later with rsp_data=0xA5.
REQ-024 Push 17 bytes 0..16 to UART_TX with uart_tx_rdy=0 -> STATUS tx_count=16, tx_full=1, tx_ovf=1; raise rdy -> bytes 0..15 emitted in order, byte 16 never emitted.
REQ-025 Pulse uart_rx_valid with 0x3C, read UART_RX twice -> 0x8000_003C, then 0x0000_0000.
REQ-026 IRQ_EN=4'b0100, gpi[2] rising -> GPI_EDGE=0x4 and irq=1; write 0x4 to GPI_EDGE -> irq=0 two cycles later.
REQ-027 Read index 12 -> rsp_error=1, rsp_data=0; assert reset with 3 TX bytes queued -> tx_count=0, uart_tx_vld stays 0.

Source files
------------

// File: rtl/mmio_periph_ctrl.sv
// MMIO peripheral controller: ID, GPO, synchronised GPI with edge capture,
// UART TX/RX byte FIFOs, status and a level interrupt.
module mmio_periph_ctrl #(
  parameter int          WL         = 32,
  parameter int          ADDR_WL    = 4,
  parameter int          N_GPI      = 8,
  parameter int          N_GPO      = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] ID_VALUE   = 32'hA7C0_0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic               cmd_wr,
  input  logic [ADDR_WL+1:0] cmd_addr,
  input  logic [WL-1:0]      cmd_wdata,
  output logic               rsp_valid,
  output logic [WL-1:0]      rsp_data,
  output logic               rsp_error,
  input  logic [N_GPI-1:0]   gpi,
  output logic [N_GPO-1:0]   gpo,
  input  logic               uart_tx_rdy,
  output logic               uart_tx_vld,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_rx_valid,
  input  logic [7:0]         uart_rx_data,
  output logic               irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  localparam cnt_t FULL = cnt_t'(FIFO_DEPTH);

  logic [ADDR_WL-1:0] idx;
  logic rd_cmd, wr_cmd;
  logic sel_id, sel_gpo, sel_gpi, sel_edge;
  logic sel_ien, sel_tx, sel_rx, sel_st;

  assign idx      = cmd_addr[ADDR_WL+1:2];
  assign rd_cmd   = cmd_valid & ~cmd_wr;
  assign wr_cmd   = cmd_valid & cmd_wr;
  assign sel_id   = idx == ADDR_WL'(0);
  assign sel_gpo  = idx == ADDR_WL'(1);
  assign sel_gpi  = idx == ADDR_WL'(2);
  assign sel_edge = idx == ADDR_WL'(3);
  assign sel_ien  = idx == ADDR_WL'(4);
  assign sel_tx   = idx == ADDR_WL'(5);
  assign sel_rx   = idx == ADDR_WL'(6);
  assign sel_st   = idx == ADDR_WL'(7);

  logic unused_ok;
  assign unused_ok = ^{cmd_addr[1:0], cmd_wdata};

  logic [N_GPI-1:0] gpi_s1, gpi_s2, gpi_d;
  logic [N_GPI-1:0] gpi_edge, edge_clr, edge_n;
  logic [3:0]       irq_en;

  assign edge_clr = (wr_cmd && sel_edge) ? cmd_wdata[N_GPI-1:0] : '0;
  assign edge_n   = (gpi_edge & ~edge_clr) | (gpi_s2 & ~gpi_d);

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  ptr_t tx_wp, tx_rp, rx_wp, rx_rp;
  cnt_t tx_cnt, rx_cnt;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_drop;
  logic rx_push, rx_pop, rx_drop;
  logic tx_ovf, rx_ovf, st_rd;

  assign tx_full  = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;

  assign tx_push = wr_cmd & sel_tx & ~tx_full;
  assign tx_drop = wr_cmd & sel_tx & tx_full;
  assign tx_pop  = ~tx_empty & uart_tx_rdy & ~uart_tx_vld;
  assign rx_push = uart_rx_valid & ~rx_full;
  assign rx_drop = uart_rx_valid & rx_full;
  assign rx_pop  = rd_cmd & sel_rx & ~rx_empty;
  assign st_rd   = rd_cmd & sel_st;

  logic [WL-1:0] rd_data;
  logic          rd_err;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      sel_id:   rd_data = WL'(ID_VALUE);
      sel_gpo:  rd_data = WL'(gpo);
      sel_gpi:  rd_data = WL'(gpi_s2);
      sel_edge: rd_data = WL'(gpi_edge);
      sel_ien:  rd_data = WL'(irq_en);
      sel_rx: begin
        if (!rx_empty) begin
          rd_data[WL-1] = 1'b1;
          rd_data[7:0]  = rx_mem[rx_rp];
        end
      end
      sel_st:
        rd_data = WL'({rx_ovf, tx_ovf, rx_empty, tx_full,
                       8'(rx_cnt), 8'(tx_cnt)});
      default:  rd_err = 1'b1;
    endcase
  end

  logic [3:0] irq_src;
  assign irq_src = {tx_ovf | rx_ovf, |gpi_edge, tx_empty, ~rx_empty};

  // Storage arrays carry no reset; the pointers/counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= cmd_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpi_s1       <= '0;
      gpi_s2       <= '0;
      gpi_d        <= '0;
      gpi_edge     <= '0;
      gpo          <= '0;
      irq_en       <= '0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      tx_cnt       <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_cnt       <= '0;
      tx_ovf       <= 1'b0;
      rx_ovf       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
      uart_tx_vld  <= 1'b0;
      uart_tx_data <= '0;
      irq          <= 1'b0;
    end else begin
      gpi_s1   <= gpi;
      gpi_s2   <= gpi_s1;
      gpi_d    <= gpi_s2;
      gpi_edge <= edge_n;
      if (wr_cmd && sel_gpo) gpo    <= cmd_wdata[N_GPO-1:0];
      if (wr_cmd && sel_ien) irq_en <= cmd_wdata[3:0];
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      tx_cnt <= tx_cnt + cnt_t'(tx_push) - cnt_t'(tx_pop);
      rx_cnt <= rx_cnt + cnt_t'(rx_push) - cnt_t'(rx_pop);
      // A fresh overflow beats the clear-on-read of STATUS.
      tx_ovf <= tx_drop | (tx_ovf & ~st_rd);
      rx_ovf <= rx_drop | (rx_ovf & ~st_rd);
      rsp_valid   <= rd_cmd;
      rsp_data    <= rd_cmd ? rd_data : '0;
      rsp_error   <= rd_cmd & rd_err;
      uart_tx_vld <= tx_pop;
      if (tx_pop) uart_tx_data <= tx_mem[tx_rp];
      irq <= |(irq_en & irq_src);
    end
  end

endmodule

// File: tb/tb_mmio_periph_ctrl.sv
// Scoreboard bench for mmio_periph_ctrl: read responses and TX bytes
// are queued at issue time and checked by an independent monitor.
module tb_mmio_periph_ctrl;

  localparam logic [31:0] ID = 32'hA7C0_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_wr;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic [7:0]  gpi, gpo;
  logic        uart_tx_rdy, uart_tx_vld;
  logic [7:0]  uart_tx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        irq;

  mmio_periph_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .gpi(gpi), .gpo(gpo),
    .uart_tx_rdy(uart_tx_rdy), .uart_tx_vld(uart_tx_vld),
    .uart_tx_data(uart_tx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       nm;
  } exp_t;

  exp_t       rq[$];
  logic [7:0] txq[$];
  exp_t       e;
  logic [7:0] eb;
  logic       prev_vld = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got data %h err %b, want none",
                 rsp_data, rsp_error);
      end else begin
        e = rq.pop_front();
        if (rsp_data !== e.data || rsp_error !== e.err || cyc != e.due) begin
          n_bad++;
          $display("FAIL %s: got data %h err %b cyc %0d want %h %b %0d",
                   e.nm, rsp_data, rsp_error, cyc, e.data, e.err, e.due);
        end
      end
    end
    if (uart_tx_vld === 1'b1) begin
      n_cmp++;
      if (txq.size() == 0) begin
        n_bad++;
        $display("FAIL tx_unexpected: got byte %h, want no pulse",
                 uart_tx_data);
      end else begin
        eb = txq.pop_front();
        if (uart_tx_data !== eb || prev_vld) begin
          n_bad++;
          $display("FAIL tx_byte: got %h b2b %b want %h b2b 0",
                   uart_tx_data, prev_vld, eb);
        end
      end
    end
    prev_vld <= uart_tx_vld;
  end

  task automatic wr(input int i, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 6'(i * 4);
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
  endtask

  task automatic rd(input int i, input logic [31:0] d, input logic er,
                    input string nm);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = 6'(i * 4);
    rq.push_back('{d, er, cyc + 1, nm});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    gpi = '0; uart_tx_rdy = 1'b0;
    uart_rx_valid = 1'b0; uart_rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_gpo", 32'(gpo), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_error", 32'(rsp_error), 0);
    check("rst_tx_vld", 32'(uart_tx_vld), 0);
    reset = 1'b0;

    rd(0, ID, 1'b0, "id");
    rd(7, 32'h0002_0000, 1'b0, "status_reset");

    wr(1, 32'h0000_00A5);
    check("gpo_after_wr", 32'(gpo), 32'hA5);
    rd(1, 32'h0000_00A5, 1'b0, "gpo_read");
    wr(0, 32'hFFFF_FFFF);
    rd(0, ID, 1'b0, "id_ro_write_ignored");

    rx_byte(8'h3C);
    rd(6, 32'h8000_003C, 1'b0, "rx_pop");
    rd(6, 32'h0000_0000, 1'b0, "rx_empty");

    for (int i = 0; i < 17; i++) wr(5, 32'(i));
    rd(7, 32'h0007_0010, 1'b0, "status_tx_full_ovf");
    rd(7, 32'h0003_0010, 1'b0, "status_ovf_cleared");
    rd(5, 32'h0, 1'b1, "tx_wo_read");
    for (int i = 0; i < 16; i++) txq.push_back(8'(i));
    uart_tx_rdy = 1'b1;
    for (int k = 0; k < 200 && txq.size() != 0; k++) @(negedge clk);
    check("tx_drain_done", 32'(txq.size()), 0);
    repeat (10) @(negedge clk);
    rd(7, 32'h0002_0000, 1'b0, "status_tx_drained");

    for (int i = 0; i < 17; i++) rx_byte(8'(8'h40 + i));
    rd(7, 32'h0008_1000, 1'b0, "status_rx_full_ovf");
    rd(6, 32'h8000_0040, 1'b0, "rx_head");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 6'(6 * 4);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    rq.push_back('{32'h8000_0041, 1'b0, cyc + 1, "rx_push_pop"});
    @(negedge clk);
    cmd_valid = 1'b0; uart_rx_valid = 1'b0;
    rd(7, 32'h0000_0F00, 1'b0, "status_push_pop");

    wr(4, 32'h4);
    check("irq_idle", 32'(irq), 0);
    gpi = 8'h04;
    repeat (4) @(negedge clk);
    check("irq_gpi_edge", 32'(irq), 1);
    rd(3, 32'h4, 1'b0, "gpi_edge");
    rd(2, 32'h4, 1'b0, "gpi_sync");
    rd(4, 32'h4, 1'b0, "irq_en");
    wr(3, 32'h4);
    check("irq_clr_1cyc", 32'(irq), 1);
    @(negedge clk);
    check("irq_clr_2cyc", 32'(irq), 0);
    rd(3, 32'h0, 1'b0, "gpi_edge_cleared");
    wr(4, 32'h2);
    check("irq_txe_before", 32'(irq), 0);
    @(negedge clk);
    check("irq_tx_empty", 32'(irq), 1);
    wr(4, 32'h0);

    rd(12, 32'h0, 1'b1, "unmapped_12");
    rd(15, 32'h0, 1'b1, "unmapped_15");
    uart_tx_rdy = 1'b0;
    wr(5, 32'h11); wr(5, 32'h22); wr(5, 32'h33);
    rd(7, 32'h0000_0F03, 1'b0, "status_tx3");
    @(negedge clk);
    reset = 1'b1;
    uart_tx_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("tx_vld_in_reset", 32'(uart_tx_vld), 0);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("tx_vld_after_reset", 32'(uart_tx_vld), 0);
    end
    check("gpo_after_reset", 32'(gpo), 0);
    rd(7, 32'h0002_0000, 1'b0, "status_after_reset");

    repeat (4) @(negedge clk);
    check("rsp_queue_empty", 32'(rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
